// File: rtl/proc_pkg.sv
// proc_pkg: constants shared by the register file, the ALU and the future decoder.
//   N_DATOS  : datapath width in bits
//   DIR_REG  : register address width (2**DIR_REG registers)
//   REG_CERO : address of the hardwired-zero register
package proc_pkg;

   localparam int N_DATOS = 32;
   localparam int DIR_REG = 4;

   localparam logic [DIR_REG-1:0] REG_CERO = 4'd0;

endpackage

// File: rtl/banco_reg.sv
// banco_reg: two-read / one-write register file with a carry flag, feeding the
// single-cycle ALU operands and capturing its result and carry-out.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset, clears all registers and cf
//   dira_i/dirb_i  read addresses for operands A and B
//   dirw_i         write address
//   dato_i         write data (ALU result)
//   we_i           register write enable
//   c_i            carry from the ALU
//   cwe_i          carry flag write enable (independent of we_i)
//   rega_o/regb_o  operands A and B (combinational reads)
//   c_o            stored carry flag
module banco_reg
   import proc_pkg::*;
#(
   parameter int N      = N_DATOS,
   parameter int DIR    = DIR_REG,
   parameter int BYPASS = 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [DIR-1:0] dira_i,
   input  logic [DIR-1:0] dirb_i,
   input  logic [DIR-1:0] dirw_i,
   input  logic [N-1:0]   dato_i,
   input  logic           we_i,
   input  logic           c_i,
   input  logic           cwe_i,
   output logic [N-1:0]   rega_o,
   output logic [N-1:0]   regb_o,
   output logic           c_o
);

   localparam int             PROF     = 2**DIR;
   localparam logic [DIR-1:0] DIR_CERO = DIR'(REG_CERO);

   logic [N-1:0] regs_q [PROF];
   logic [N-1:0] regs_d [PROF];
   logic         cf_q;
   logic         cf_d;
   logic         escribe;

   // A write to r0 is dropped here so that neither storage nor the
   // forwarding path ever sees it.
   assign escribe = we_i && (dirw_i != DIR_CERO);

   always_comb begin
      regs_d = regs_q;
      if (escribe) begin
         regs_d[dirw_i] = dato_i;
      end
      regs_d[0] = '0;
      cf_d = cwe_i ? c_i : cf_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < PROF; i++) begin
            regs_q[i] <= '0;
         end
         cf_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         cf_q   <= cf_d;
      end
   end

   // Address 0 is forced to zero ahead of the forwarding check so r0 stays
   // zero even while a (discarded) write to it is in flight.
   function automatic logic [N-1:0] leer(input logic [DIR-1:0] dir);
      logic [N-1:0] dato;
      if (dir == DIR_CERO) begin
         dato = '0;
      end else if ((BYPASS != 0) && escribe && (dir == dirw_i)) begin
         dato = dato_i;
      end else begin
         dato = regs_q[dir];
      end
      return dato;
   endfunction

   always_comb begin
      rega_o = leer(dira_i);
      regb_o = leer(dirb_i);
   end

   // The carry flag is deliberately not forwarded.
   assign c_o = cf_q;

endmodule

// File: tb/tb_banco_reg.sv
module tb_banco_reg;
   import proc_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  dira_i, dirb_i, dirw_i;
   logic [31:0] dato_i;
   logic        we_i, c_i, cwe_i;
   logic [31:0] rega0, regb0, rega1, regb1;
   logic        c0, c1;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [16];
   logic        cf;

   always #5 clk_i = ~clk_i;

   banco_reg #(.N(32), .DIR(4), .BYPASS(0)) dut0 (
      .clk_i(clk_i), .rst_i(rst_i), .dira_i(dira_i), .dirb_i(dirb_i),
      .dirw_i(dirw_i), .dato_i(dato_i), .we_i(we_i), .c_i(c_i), .cwe_i(cwe_i),
      .rega_o(rega0), .regb_o(regb0), .c_o(c0)
   );

   banco_reg #(.N(32), .DIR(4), .BYPASS(1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .dira_i(dira_i), .dirb_i(dirb_i),
      .dirw_i(dirw_i), .dato_i(dato_i), .we_i(we_i), .c_i(c_i), .cwe_i(cwe_i),
      .rega_o(rega1), .regb_o(regb1), .c_o(c1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
      if (a == 4'd0) return 32'h0;
      if (byp && we_i && dirw_i != 4'd0 && a == dirw_i) return dato_i;
      return mem[a];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_a0"}, rega0, exp_rd(dira_i, 1'b0));
      chk({tag, "_b0"}, regb0, exp_rd(dirb_i, 1'b0));
      chk({tag, "_c0"}, {31'h0, c0}, {31'h0, cf});
      chk({tag, "_a1"}, rega1, exp_rd(dira_i, 1'b1));
      chk({tag, "_b1"}, regb1, exp_rd(dirb_i, 1'b1));
      chk({tag, "_c1"}, {31'h0, c1}, {31'h0, cf});
   endtask

   // One instruction: settle, compare against the model, clock, update the model.
   task automatic ciclo(input string tag);
      #2;
      check_all(tag);
      @(posedge clk_i);
      if (!rst_i) begin
         if (we_i && dirw_i != 4'd0) mem[dirw_i] = dato_i;
         if (cwe_i) cf = c_i;
      end
      #1;
   endtask

   task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] w,
                         input logic [31:0] d, input logic we, input logic c, input logic cwe);
      dira_i = a; dirb_i = b; dirw_i = w; dato_i = d; we_i = we; c_i = c; cwe_i = cwe;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      cf = 1'b0;
   endtask

   initial begin
      model_reset();
      rst_i = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      #12;
      check_all("rst_init");
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // write / read
      set_in(0, 0, 3, 32'hDEADBEEF, 1, 0, 0);
      ciclo("wr3");
      set_in(3, 3, 0, 0, 0, 0, 0);
      #2;
      chk("rd3_a", rega0, 32'hDEADBEEF);
      chk("rd3_b", regb0, 32'hDEADBEEF);
      ciclo("rd3");

      // r0 protection, including the forwarding path
      set_in(0, 0, 0, 32'hFFFFFFFF, 1, 0, 0);
      #2;
      chk("r0_byp", rega1, 32'h0);
      ciclo("r0_wr");
      set_in(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("r0_rd", rega0, 32'h0);
      ciclo("r0_rd");

      // forwarding vs. old value
      set_in(0, 0, 7, 32'h1, 1, 0, 0);
      ciclo("wr7");
      set_in(7, 7, 7, 32'h2, 1, 0, 0);
      #2;
      chk("byp_on", rega1, 32'h2);
      chk("byp_off", rega0, 32'h1);
      ciclo("byp");
      set_in(7, 0, 0, 0, 0, 0, 0);
      #2;
      chk("byp_off_after", rega0, 32'h2);
      ciclo("byp_after");

      // carry flag
      set_in(0, 0, 0, 0, 0, 1, 0);
      ciclo("cf_nowe");
      chk("cf_hold0", {31'h0, c0}, 32'h0);
      set_in(0, 0, 0, 0, 0, 1, 1);
      ciclo("cf_we");
      chk("cf_set", {31'h0, c0}, 32'h1);
      set_in(0, 0, 4, 32'h55, 1, 0, 0);
      ciclo("cf_regwr");
      chk("cf_keep", {31'h0, c0}, 32'h1);

      // async reset mid-cycle with contents loaded, writes ignored during reset
      set_in(3, 7, 5, 32'h12345678, 0, 0, 0);
      #2;
      rst_i = 1'b1;
      model_reset();
      #1;
      chk("rst_async_a", rega0, 32'h0);
      chk("rst_async_b", regb0, 32'h0);
      chk("rst_async_c", {31'h0, c0}, 32'h0);
      set_in(5, 5, 5, 32'hCAFEF00D, 1, 1, 1);
      ciclo("rst_wr");
      #4;
      rst_i = 1'b0;
      set_in(5, 5, 0, 0, 0, 0, 0);
      #2;
      chk("rst_r5", rega0, 32'h0);
      ciclo("rst_r5");

      // closed loop with an ALU adder (unbypassed instance drives the sum)
      set_in(0, 0, 1, 32'hFFFFFFFF, 1, 0, 0);
      ciclo("pre1");
      set_in(0, 0, 2, 32'h1, 1, 0, 0);
      ciclo("pre2");
      set_in(1, 2, 3, 0, 1, 0, 1);
      #1;
      {c_i, dato_i} = {1'b0, rega0} + {1'b0, regb0};
      ciclo("alu_add");
      set_in(3, 3, 0, 0, 0, 0, 0);
      #2;
      chk("alu_r3", rega0, 32'h0);
      chk("alu_c", {31'h0, c0}, 32'h1);
      ciclo("alu_rd");

      // randomized instructions with occasional async reset
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 0, 0, 0, 0);
            rst_i = 1'b1;
            model_reset();
            #1;
            check_all("rnd_rst");
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            ciclo("rnd_rst_hold");
            #4;
            rst_i = 1'b0;
         end
         set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) dira_i = dirw_i;
         if ($urandom_range(0, 3) == 0) dirb_i = dirw_i;
         ciclo("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/banco_reg.md
# banco_reg

Register file with carry flag for the single-cycle datapath. It sits directly upstream of the 32-bit ALU and replaces the fixed operand ROMs as its operand source. Two 4-bit read addresses select the ALU A/B operands, and one write port accepts the ALU result for write-back. A 1-bit carry flag register captures the ALU carry-out and feeds it back as carry-in.

## Interface
Parameters:
- N, 32, register width in bits; matches ALU width.
- DIR, 4, address width; depth is 2**DIR (16 registers).
- BYPASS, 1, 1 = write-to-read forwarding enabled, 0 = disabled.

Ports:
- clk_i, input, 1: single clock, rising-edge.
- rst_i, input, 1: reset, asynchronous, active-high.
- dira_i, input, DIR: read address for port A.
- dirb_i, input, DIR: read address for port B.
- dirw_i, input, DIR: write address.
- dato_i, input, N: write data (ALU result).
- we_i, input, 1: register write enable.
- c_i, input, 1: carry from ALU c_o.
- cwe_i, input, 1: carry flag write enable.
- rega_o, output, N: operand A to ALU A_i.
- regb_o, output, N: operand B to ALU B_i.
- c_o, output, 1: stored carry flag to ALU c_i.

## Operation
- Storage: registers r0..r(2**DIR-1), each N bits, plus carry flag cf.
- r0 is hardwired to 0:
  - Writes to dirw_i == 0 are discarded.
  - Reads of address 0 always return 0, including when bypass would otherwise apply.
- Write: at a rising clk_i with we_i=1 and dirw_i≠0, r[dirw_i] ← dato_i.
- Carry: at a rising clk_i with cwe_i=1, cf ← c_i. cwe_i is independent of we_i.
- Read: rega_o and regb_o are combinational from the addresses and register contents.
  - If BYPASS=1, we_i=1, dirw_i≠0, and the read address equals dirw_i, the output is dato_i; otherwise it is r[addr].
  - A and B may use the same address; both then return identical data.
- c_o is the value of cf. The carry flag is not bypassed.
- Reset: all registers and cf clear to 0 immediately on assertion, regardless of clk_i.
  - rega_o, regb_o and c_o read 0 during reset, unless BYPASS forwarding of dato_i is active.
  - Writes are ignored while rst_i=1.
  - Deasserting reset mid-sequence leaves no partial writes.

## Timing
- Read latency 0 cycles (combinational). Write latency 1 cycle: new data is visible at the outputs after the next rising edge.
- With BYPASS=1, write data is visible in the same cycle through the forwarding path.
- A simultaneous read and write of the same address in one cycle returns:
  - BYPASS=0: the old value.
  - BYPASS=1: the new value.
- There is no handshake. Each cycle is one instruction: address, ALU, write-back.
- Combinational path is dirw_i/dato_i → rega_o/regb_o when BYPASS=1. The top level must not close a loop through the ALU back to dato_i with bypass enabled. The single-cycle top therefore instantiates BYPASS=0.
- Reset values: all r = 0, cf = 0, c_o = 0.

## Structure
- Shared package (proc_pkg):
  - N_DATOS=32.
  - DIR_REG=4.
  - Constant REG_CERO=4'd0.
  - These constants are shared with the ALU and the future decoder.
- Single module. There is no natural sub-module; the carry flag stays inline as one flip-flop.
- Integration at the top level:
  - rega_o → ALU A_i.
  - regb_o → ALU B_i.
  - c_o → ALU c_i.
  - ALU c_o → c_i.
  - ALU sal_o → dato_i.
  - Display decoders unchanged.

## Test plan
- Reset: assert rst_i mid-cycle with prior contents loaded → rega_o=regb_o=0 and c_o=0 immediately, without waiting for a clock edge. After release, reading r5 returns 0.
- Write/read: we_i=1, dirw_i=3, dato_i=32'hDEADBEEF; next cycle dira_i=3, dirb_i=3 → rega_o=regb_o=32'hDEADBEEF.
- r0 protection: we_i=1, dirw_i=0, dato_i=32'hFFFFFFFF; then dira_i=0 → rega_o=0. With BYPASS=1 in the same cycle, rega_o is still 0.
- Bypass: BYPASS=1, r7=32'h1, same cycle we_i=1, dirw_i=7, dato_i=32'h2, dira_i=7 → rega_o=32'h2. With BYPASS=0 under the same stimulus → rega_o=32'h1 until the edge, then 32'h2.
- Carry: c_i=1, cwe_i=0 at an edge → c_o stays 0. Then c_i=1, cwe_i=1 → c_o=1 after the edge. Then we_i writes with cwe_i=0 → c_o holds 1.
- Closed loop with the ALU (BYPASS=0):
  - Preload r1=32'hFFFFFFFF and r2=32'h1.
  - Perform an add op into r3 with cwe_i=1 → r3=32'h0 and c_o=1 on the next cycle.
